// File: rtl/game_controller.sv
// game_controller: two-player code-guess sequencer; Clk/Reset/Start/Enter/Switches in, Phase/Attempt_Valid/Attempt_State/Attempts_Left/Display/Game_Won/Game_Lost/Hint_Higher/Hint_Lower out; define GAME_HINT_EN to build the hint compare
module game_controller #(
  parameter int CODE_WIDTH   = 3,
  parameter int MAX_ATTEMPTS = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Enter,
  input  logic [CODE_WIDTH-1:0] Switches,
  output logic [2:0]            Phase,
  output logic                  Attempt_Valid,
  output logic                  Attempt_State,
  output logic [3:0]            Attempts_Left,
  output logic [7:0]            Display,
  output logic                  Game_Won,
  output logic                  Game_Lost,
  output logic                  Hint_Higher,
  output logic                  Hint_Lower
);
  typedef enum logic [2:0] {IDLE, SET_SECRET, WAIT_GUESS, CHECK, WON, LOST} state_t;
  localparam logic [3:0] MAX = 4'(MAX_ATTEMPTS);
  state_t state, state_nxt;
  logic start_old, enter_old, start_rise, enter_rise, match;
  logic [CODE_WIDTH-1:0] secret, guess, secret_nxt, guess_nxt;
  logic [3:0] left_nxt;
  logic valid_nxt, astate_nxt, won_nxt, lost_nxt;
  assign start_rise = Start & ~start_old;
  assign enter_rise = Enter & ~enter_old;
  assign match = guess == secret;
  assign Phase = state;
  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 8'hC0;
      4'd1: seg = 8'hF9;
      4'd2: seg = 8'hA4;
      4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99;
      4'd5: seg = 8'h92;
      4'd6: seg = 8'h82;
      4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80;
      4'd9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction
  always_comb begin
    state_nxt = state;
    secret_nxt = secret;
    guess_nxt = guess;
    left_nxt = Attempts_Left;
    valid_nxt = 1'b0;
    astate_nxt = Attempt_State;
    won_nxt = Game_Won;
    lost_nxt = Game_Lost;
    case (state)
      IDLE: if (start_rise) begin
        state_nxt = SET_SECRET;
        left_nxt = MAX;
      end
      SET_SECRET: if (enter_rise) begin
        secret_nxt = Switches;
        state_nxt = WAIT_GUESS;
      end
      WAIT_GUESS: if (enter_rise) begin
        guess_nxt = Switches;
        state_nxt = CHECK;
      end
      CHECK: begin
        valid_nxt = 1'b1;
        astate_nxt = match;
        if (match) begin
          won_nxt = 1'b1;
          state_nxt = WON;
        end else begin
          left_nxt = Attempts_Left - 4'd1;
          lost_nxt = left_nxt == 4'd0;
          state_nxt = lost_nxt ? LOST : WAIT_GUESS;
        end
      end
      WON, LOST: if (start_rise) begin
        state_nxt = SET_SECRET;
        left_nxt = MAX;
        won_nxt = 1'b0;
        lost_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      start_old <= 1'b1;
      enter_old <= 1'b1;
      secret <= '0;
      guess <= '0;
      Attempts_Left <= 4'd0;
      Attempt_Valid <= 1'b0;
      Attempt_State <= 1'b0;
      Game_Won <= 1'b0;
      Game_Lost <= 1'b0;
      Display <= 8'hFF;
    end else begin
      state <= state_nxt;
      start_old <= Start;
      enter_old <= Enter;
      secret <= secret_nxt;
      guess <= guess_nxt;
      Attempts_Left <= left_nxt;
      Attempt_Valid <= valid_nxt;
      Attempt_State <= astate_nxt;
      Game_Won <= won_nxt;
      Game_Lost <= lost_nxt;
      Display <= state == IDLE ? 8'hFF : seg(Attempts_Left);
    end
  end
`ifdef GAME_HINT_EN
  logic restart;
  assign restart = start_rise & (state == WON || state == LOST);
  always_ff @(posedge Clk) begin
    if (Reset || restart) begin
      Hint_Higher <= 1'b0;
      Hint_Lower <= 1'b0;
    end else if (state == CHECK) begin
      Hint_Higher <= ~match & (secret > guess);
      Hint_Lower <= ~match & (secret < guess);
    end
  end
`else
  assign Hint_Higher = 1'b0;
  assign Hint_Lower = 1'b0;
`endif
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed checks of game_controller with default parameters
module tb_game_controller;
  logic clk = 1'b0;
  logic reset, start, enter;
  logic [2:0] switches, phase;
  logic attempt_valid, attempt_state, game_won, game_lost, hint_higher, hint_lower;
  logic [3:0] attempts_left;
  logic [7:0] display;
  int checks = 0;
  int errors = 0;
  int pulses;
`ifdef GAME_HINT_EN
  localparam logic HINT = 1'b1;
`else
  localparam logic HINT = 1'b0;
`endif
  game_controller dut (
    .Clk(clk), .Reset(reset), .Start(start), .Enter(enter), .Switches(switches),
    .Phase(phase), .Attempt_Valid(attempt_valid), .Attempt_State(attempt_state),
    .Attempts_Left(attempts_left), .Display(display), .Game_Won(game_won),
    .Game_Lost(game_lost), .Hint_Higher(hint_higher), .Hint_Lower(hint_lower)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic press_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic set_code(input logic [2:0] v);
    switches = v;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask
  task automatic do_guess(input logic [2:0] v);
    switches = v;
    enter = 1'b1;
    tick();
    chk("check_phase", phase, 3);
    enter = 1'b0;
    tick();
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    enter = 1'b0;
    switches = '0;
    tick();
    tick();
    chk("rst_phase", phase, 0);
    chk("rst_left", attempts_left, 0);
    chk("rst_display", display, 8'hFF);
    chk("rst_flags", {attempt_valid, attempt_state, game_won, game_lost, hint_higher, hint_lower}, 0);
    reset = 1'b0;
    tick();
    press_start();
    chk("start_phase", phase, 1);
    chk("start_left", attempts_left, 5);
    set_code(3'd5);
    chk("secret_phase", phase, 2);
    do_guess(3'd5);
    chk("win_valid", attempt_valid, 1);
    chk("win_state", attempt_state, 1);
    chk("win_flag", game_won, 1);
    chk("win_phase", phase, 4);
    chk("win_left", attempts_left, 5);
    tick();
    chk("win_valid_clr", attempt_valid, 0);
    chk("win_display", display, 8'h92);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    chk("won_enter_ignored", phase, 4);
    press_start();
    chk("restart_phase", phase, 1);
    chk("restart_won", game_won, 0);
    chk("restart_left", attempts_left, 5);
    set_code(3'd7);
    for (int i = 0; i < 5; i++) begin
      do_guess(3'(i));
      chk("miss_valid", attempt_valid, 1);
      chk("miss_state", attempt_state, 0);
      chk("miss_left", attempts_left, 4 - i);
      chk("miss_phase", phase, i < 4 ? 2 : 5);
      chk("miss_lost", game_lost, i == 4);
      chk("miss_hint", {hint_higher, hint_lower}, {HINT, 1'b0});
    end
    tick();
    chk("lost_valid_clr", attempt_valid, 0);
    chk("lost_display", display, 8'hC0);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    chk("lost_enter_phase", phase, 5);
    chk("lost_enter_left", attempts_left, 0);
    chk("lost_enter_valid", attempt_valid, 0);
    press_start();
    chk("relost_phase", phase, 1);
    chk("relost_lost", game_lost, 0);
    chk("relost_hint", {hint_higher, hint_lower}, 0);
    set_code(3'd3);
    switches = 3'd1;
    enter = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (attempt_valid) pulses++;
    end
    enter = 1'b0;
    tick();
    chk("held_pulses", pulses, 1);
    chk("held_left", attempts_left, 4);
    chk("held_phase", phase, 2);
    do_guess(3'd0);
    do_guess(3'd0);
    chk("pre_reset_left", attempts_left, 2);
    reset = 1'b1;
    tick();
    chk("mid_rst_phase", phase, 0);
    chk("mid_rst_left", attempts_left, 0);
    chk("mid_rst_display", display, 8'hFF);
    chk("mid_rst_flags", {attempt_valid, attempt_state, game_won, game_lost, hint_higher, hint_lower}, 0);
    enter = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    press_start();
    tick();
    tick();
    chk("held_thru_reset", phase, 1);
    enter = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    switches = 3'd2;
    start = 1'b1;
    enter = 1'b1;
    tick();
    chk("both_phase", phase, 1);
    start = 1'b0;
    tick();
    chk("both_consumed", phase, 1);
    enter = 1'b0;
    tick();
    set_code(3'd4);
    do_guess(3'd2);
    chk("hint_low_guess", {hint_higher, hint_lower}, {HINT, 1'b0});
    do_guess(3'd6);
    chk("hint_high_guess", {hint_higher, hint_lower}, {1'b0, HINT});
    do_guess(3'd4);
    chk("hint_match", {hint_higher, hint_lower}, 0);
    chk("final_won", game_won, 1);
    chk("final_left", attempts_left, 3);
    tick();
    chk("final_display", display, 8'hB0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
